// File: rtl/fetch_queue_pkg.sv
// Shared constants and entry type for the instruction fetch queue.
package fetch_queue_pkg;

  localparam int          FQ_DEPTH    = 4;
  localparam logic [31:0] FQ_RESET_PC = 32'h0000_0000;
  localparam int          FQ_INSTR_W  = 32;
  localparam logic [31:0] FQ_PC_INCR  = 32'd4;

  typedef struct packed {
    logic [FQ_INSTR_W-1:0] instr;
    logic [31:0]           pc_incr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Generic synchronous FIFO: combinational head read, clear beats push/pop.
module sync_fifo #(
  parameter int  WIDTH = 64,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge clk) begin
    if (!rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (rst && !i_clear && i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: one-cycle memory, slot reservation for the in-flight read, redirect flush.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = FQ_DEPTH,
  parameter logic [31:0] RESET_PC = FQ_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic [31:0]           mem_addr,
  input  logic [31:0]           mem_rdata,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [31:0]           out_pc_incr,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_inflight_addr;
  logic          r_inflight;

  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_occupancy;
  fq_entry_t     w_wdata;
  fq_entry_t     w_head;

  // The outstanding read already owns a slot, so it is counted as occupancy.
  assign w_occupancy = w_count + CW'(r_inflight);
  assign w_issue     = rst && !redirect && (w_occupancy < CW'(DEPTH));
  assign w_push      = rst && !redirect && r_inflight;
  assign w_pop       = rst && !redirect && out_valid && out_ready;

  assign w_wdata.instr   = mem_rdata;
  assign w_wdata.pc_incr = r_inflight_addr + FQ_PC_INCR;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fetch_pc      <= RESET_PC;
      r_inflight      <= 1'b0;
      r_inflight_addr <= '0;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_addr <= r_fetch_pc;
        r_fetch_pc      <= r_fetch_pc + FQ_PC_INCR;
      end
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fq_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clear (redirect),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  assign mem_req     = w_issue;
  assign mem_addr    = r_fetch_pc;
  assign count       = w_count;
  assign out_valid   = rst && (w_count != '0);
  assign out_instr   = out_valid ? w_head.instr   : '0;
  assign out_pc_incr = out_valid ? w_head.pc_incr : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue; memory model returns the request address as data.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst, redirect, out_ready;
  logic [31:0] redirect_pc, mem_rdata, mem_addr, out_instr, out_pc_incr;
  logic        mem_req, out_valid;
  logic [2:0]  count;

  logic        rst2, redirect2, out_ready2;
  logic [31:0] redirect_pc2, mem_rdata2, mem_addr2, out_instr2, out_pc_incr2;
  logic        mem_req2, out_valid2;
  logic [2:0]  count2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc_incr(out_pc_incr), .count(count)
  );

  fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst2), .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2),
    .redirect(redirect2), .redirect_pc(redirect_pc2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_instr(out_instr2), .out_pc_incr(out_pc_incr2), .count(count2)
  );

  // One-cycle instruction memory; unrequested cycles return a poison word.
  always @(posedge clk) begin
    mem_rdata  <= mem_req  ? mem_addr  : 32'hDEAD_BEEF;
    mem_rdata2 <= mem_req2 ? mem_addr2 : 32'hDEAD_BEEF;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 ns into the first cycle after reset release.
  task automatic do_reset(input logic rdy);
    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = rdy;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr: got %h want 0", out_instr); end
    n_cmp++; if (out_pc_incr !== 32'h0) begin n_fail++; $display("FAIL reset_out_pc_incr: got %h want 0", out_pc_incr); end
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL reset2_out_valid: got %b want 0", out_valid2); end
    tick();
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL stream_req c%0d: got %b want 1", k, mem_req); end
      n_cmp++; if (mem_addr !== 32'(4 * k)) begin n_fail++; $display("FAIL stream_addr c%0d: got %h want %h", k, mem_addr, 32'(4 * k)); end
      n_cmp++; if (out_valid !== (k >= 2)) begin n_fail++; $display("FAIL stream_valid c%0d: got %b want %b", k, out_valid, k >= 2); end
      if (k >= 2) begin
        n_cmp++; if (out_instr !== 32'(4 * (k - 2))) begin n_fail++; $display("FAIL stream_instr c%0d: got %h want %h", k, out_instr, 32'(4 * (k - 2))); end
        n_cmp++; if (out_pc_incr !== 32'(4 * (k - 1))) begin n_fail++; $display("FAIL stream_pc_incr c%0d: got %h want %h", k, out_pc_incr, 32'(4 * (k - 1))); end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset(1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k >= 5) begin
        n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL stall_count c%0d: got %0d want 4", k, count); end
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req c%0d: got %b want 0", k, mem_req); end
        n_cmp++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL stall_instr c%0d: got %h want 0", k, out_instr); end
        n_cmp++; if (out_pc_incr !== 32'h4) begin n_fail++; $display("FAIL stall_pc_incr c%0d: got %h want 4", k, out_pc_incr); end
      end
      tick();
    end
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid p%0d: got %b want 1", j, out_valid); end
      n_cmp++; if (out_instr !== 32'(4 * j)) begin n_fail++; $display("FAIL drain_instr p%0d: got %h want %h", j, out_instr, 32'(4 * j)); end
      n_cmp++; if (out_pc_incr !== 32'(4 * j + 4)) begin n_fail++; $display("FAIL drain_pc_incr p%0d: got %h want %h", j, out_pc_incr, 32'(4 * j + 4)); end
      if (j == 1) begin
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin n_fail++; $display("FAIL drain_resume: got req=%b addr=%h want req=1 addr=00000010", mem_req, mem_addr); end
      end
      tick();
    end
    @(negedge clk);
    n_cmp++; if (out_instr !== 32'h10) begin n_fail++; $display("FAIL drain_refetch_instr: got %h want 00000010", out_instr); end
    tick();
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    repeat (4) tick();
    redirect = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL redir_pre_count: got %0d want 3", count); end
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL redir_req: got %b want 0", mem_req); end
    tick();
    redirect = 1'b0;
    @(negedge clk);
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL redir_count: got %0d want 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid: got %b want 0", out_valid); end
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin n_fail++; $display("FAIL redir_addr: got req=%b addr=%h want req=1 addr=00000100", mem_req, mem_addr); end
    tick();
    @(negedge clk);
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL redir_stale_drop: got count %0d want 0", count); end
    tick();
    @(negedge clk);
    n_cmp++; if (out_instr !== 32'h100 || out_pc_incr !== 32'h104) begin n_fail++; $display("FAIL redir_first: got instr=%h pc_incr=%h want 00000100/00000104", out_instr, out_pc_incr); end
    tick();
  endtask

  task automatic test_redirect_full();
    do_reset(1'b0);
    repeat (4) tick();
    out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || count !== 3'd3) begin n_fail++; $display("FAIL full_pre: got valid=%b count=%0d want 1/3", out_valid, count); end
    tick();
    redirect = 1'b0;
    @(negedge clk);
    n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL full_flush: got count=%0d valid=%b want 0/0", count, out_valid); end
    n_cmp++; if (mem_addr !== 32'h200) begin n_fail++; $display("FAIL full_addr: got %h want 00000200", mem_addr); end
    repeat (2) tick();
    @(negedge clk);
    n_cmp++; if (out_instr !== 32'h200 || out_pc_incr !== 32'h204 || count !== 3'd1) begin n_fail++; $display("FAIL full_first: got instr=%h pc_incr=%h count=%0d want 00000200/00000204/1", out_instr, out_pc_incr, count); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset(1'b1);
    repeat (3) tick();
    redirect = 1'b1; redirect_pc = 32'h300;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL b2b_req1: got %b want 0", mem_req); end
    tick();
    redirect_pc = 32'h400;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL b2b_req2: got req=%b count=%0d want 0/0", mem_req, count); end
    tick();
    redirect = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h400 || out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_addr: got req=%b addr=%h valid=%b want 1/00000400/0", mem_req, mem_addr, out_valid); end
    repeat (2) tick();
    @(negedge clk);
    n_cmp++; if (out_instr !== 32'h400 || out_pc_incr !== 32'h404) begin n_fail++; $display("FAIL b2b_first: got instr=%h pc_incr=%h want 00000400/00000404", out_instr, out_pc_incr); end
    tick();
  endtask

  task automatic test_mid_reset();
    do_reset(1'b0);
    repeat (3) tick();
    @(negedge clk);
    n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL midrst_pre_count: got %0d want 2", count); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0 || out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc_incr !== 32'h0) begin n_fail++; $display("FAIL midrst_during: got req=%b valid=%b instr=%h pc_incr=%h want all zero", mem_req, out_valid, out_instr, out_pc_incr); end
    tick();
    rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_after: got count=%0d valid=%b want 0/0", count, out_valid); end
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL midrst_refetch: got req=%b addr=%h want 1/00000000", mem_req, mem_addr); end
    repeat (2) tick();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_pc_incr !== 32'h4) begin n_fail++; $display("FAIL midrst_first: got valid=%b pc_incr=%h want 1/00000004", out_valid, out_pc_incr); end
    tick();
  endtask

  task automatic test_wrap();
    logic [31:0] base;
    base = 32'hFFFF_FFF8;
    rst2 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 3) begin
        n_cmp++; if (mem_req2 !== 1'b1 || mem_addr2 !== base + 32'(4 * k)) begin n_fail++; $display("FAIL wrap_addr c%0d: got req=%b addr=%h want 1/%h", k, mem_req2, mem_addr2, base + 32'(4 * k)); end
      end
      if (k >= 2) begin
        n_cmp++; if (out_instr2 !== base + 32'(4 * (k - 2))) begin n_fail++; $display("FAIL wrap_instr c%0d: got %h want %h", k, out_instr2, base + 32'(4 * (k - 2))); end
        n_cmp++; if (out_pc_incr2 !== base + 32'(4 * (k - 1))) begin n_fail++; $display("FAIL wrap_pc_incr c%0d: got %h want %h", k, out_pc_incr2, base + 32'(4 * (k - 1))); end
      end
      tick();
    end
  endtask

  initial begin
    rst2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = '0; out_ready2 = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_full();
    test_back_to_back();
    test_mid_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
